// File: rtl/rect_fill_if.sv
// Bundle of the fill request, the RAM write port and the status
// signals between a rect_fill_engine and its surroundings.
interface rect_fill_if #(
  parameter int ADDR_W = 15
);
  logic              start;
  logic [7:0]        x0;
  logic [6:0]        y0;
  logic [7:0]        x1;
  logic [6:0]        y1;
  logic [11:0]       colour;
  logic              slot_free;
  logic              busy;
  logic              done;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [11:0]       wr_data;

  modport master (
    output start, x0, y0, x1, y1, colour, slot_free,
    input  busy, done, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  start, x0, y0, x1, y1, colour, slot_free,
    output busy, done, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/rect_fill_engine.sv
// Fills a clipped, corner-normalised rectangle of the picture buffer with one
// colour, issuing one RAM write per cycle in which the write slot is free.
//
// state  | meaning
// S_IDLE | waiting for start; request fields latched on start
// S_LOAD | clip, order corners, seed col/row/row_base (one cycle)
// S_FILL | one write per free slot, row-major
// S_DONE | one-cycle done pulse
module rect_fill_engine #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int ADDR_W = 15
) (
  input logic         clk,
  input logic         reset,
  rect_fill_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0]        X_MAX    = 8'(WIDTH - 1);
  localparam logic [6:0]        Y_MAX    = 7'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] W_STRIDE = ADDR_W'(WIDTH);

  state_t            r_state;
  state_t            w_next;

  logic [7:0]        r_x0;
  logic [6:0]        r_y0;
  logic [7:0]        r_x1;
  logic [6:0]        r_y1;
  logic [11:0]       r_colour;
  logic [7:0]        r_xl;
  logic [7:0]        r_xr;
  logic [6:0]        r_yt;
  logic [6:0]        r_yb;
  logic [7:0]        r_col;
  logic [6:0]        r_row;
  logic [ADDR_W-1:0] r_row_base;

  logic [7:0]        w_cx0;
  logic [7:0]        w_cx1;
  logic [6:0]        w_cy0;
  logic [6:0]        w_cy1;
  logic [7:0]        w_xl;
  logic [7:0]        w_xr;
  logic [6:0]        w_yt;
  logic [6:0]        w_yb;
  logic              w_wr_en;
  logic              w_busy;
  logic              w_done;
  logic              w_col_end;
  logic              w_row_end;

  // Constant multiply by WIDTH expressed as a sum of shifted copies of y.
  function automatic logic [ADDR_W-1:0] row_offset(input logic [6:0] y);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (WIDTH[i]) acc = acc + (ADDR_W'(y) << i);
    end
    return acc;
  endfunction

  // Clip against the buffer edge, then order the corners.
  assign w_cx0 = (r_x0 > X_MAX) ? X_MAX : r_x0;
  assign w_cx1 = (r_x1 > X_MAX) ? X_MAX : r_x1;
  assign w_cy0 = (r_y0 > Y_MAX) ? Y_MAX : r_y0;
  assign w_cy1 = (r_y1 > Y_MAX) ? Y_MAX : r_y1;
  assign w_xl  = (w_cx0 < w_cx1) ? w_cx0 : w_cx1;
  assign w_xr  = (w_cx0 < w_cx1) ? w_cx1 : w_cx0;
  assign w_yt  = (w_cy0 < w_cy1) ? w_cy0 : w_cy1;
  assign w_yb  = (w_cy0 < w_cy1) ? w_cy1 : w_cy0;

  assign w_col_end = (r_col >= r_xr);
  assign w_row_end = (r_row >= r_yb);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_wr_en = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_busy = 1'b1;
        w_next = S_FILL;
      end
      S_FILL: begin
        w_busy  = 1'b1;
        w_wr_en = bus.slot_free;
        if (bus.slot_free && w_col_end && w_row_end) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x0       <= '0;
      r_y0       <= '0;
      r_x1       <= '0;
      r_y1       <= '0;
      r_colour   <= '0;
      r_xl       <= '0;
      r_xr       <= '0;
      r_yt       <= '0;
      r_yb       <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_x0     <= bus.x0;
            r_y0     <= bus.y0;
            r_x1     <= bus.x1;
            r_y1     <= bus.y1;
            r_colour <= bus.colour;
          end
        end
        S_LOAD: begin
          r_xl       <= w_xl;
          r_xr       <= w_xr;
          r_yt       <= w_yt;
          r_yb       <= w_yb;
          r_col      <= w_xl;
          r_row      <= w_yt;
          r_row_base <= row_offset(w_yt);
        end
        S_FILL: begin
          // A busy slot holds the position so no pixel is skipped or repeated.
          if (w_wr_en) begin
            if (!w_col_end) begin
              r_col <= r_col + 8'd1;
            end else if (!w_row_end) begin
              r_col      <= r_xl;
              r_row      <= r_row + 7'd1;
              r_row_base <= r_row_base + W_STRIDE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.wr_en   = w_wr_en;
  assign bus.wr_addr = r_row_base + ADDR_W'(r_col);
  assign bus.wr_data = r_colour;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: reset, basic, clipped, stalled,
// single-pixel, back-to-back, reset mid-fill and full-screen fills.
module tb_rect_fill_engine;

  logic clk = 1'b0;
  logic reset;

  rect_fill_if #(.ADDR_W(15)) bus ();

  rect_fill_engine #(
    .WIDTH (160),
    .HEIGHT(120),
    .ADDR_W(15)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int           wr_count = 0;
  int           done_cnt = 0;
  logic [14:0]  last_addr = '0;

  always @(posedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wr_count  <= wr_count + 1;
      last_addr <= bus.wr_addr;
    end
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_rect(input logic [7:0] a, input logic [6:0] b,
                          input logic [7:0] c, input logic [6:0] d,
                          input logic [11:0] col);
    bus.x0     = a;
    bus.y0     = b;
    bus.x1     = c;
    bus.y1     = d;
    bus.colour = col;
  endtask

  // Called at a negedge in IDLE; returns #1 after the negedge in LOAD.
  task automatic kick();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
  endtask

  // Checks a fill with slot_free held at 1, starting from the LOAD cycle.
  task automatic run_seq(input string tag, input int ea[$], input logic [11:0] col);
    chk({tag, "_load_busy"}, bus.busy, 1);
    chk({tag, "_load_wren"}, bus.wr_en, 0);
    @(negedge clk); #1;
    foreach (ea[i]) begin
      chk({tag, "_wren"}, bus.wr_en, 1);
      chk({tag, "_addr"}, bus.wr_addr, ea[i]);
      chk({tag, "_data"}, bus.wr_data, col);
      chk({tag, "_busy"}, bus.busy, 1);
      @(negedge clk); #1;
    end
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_done_busy"}, bus.busy, 0);
    chk({tag, "_done_wren"}, bus.wr_en, 0);
    @(negedge clk); #1;
    chk({tag, "_idle_done"}, bus.done, 0);
  endtask

  initial begin
    int q[$];
    int idx;
    int k;
    int gaps;
    int w0;
    int d0;
    bit seen;
    logic pat [4];

    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.slot_free = 1'b1;
    set_rect(8'd0, 7'd0, 8'd0, 7'd0, 12'h000);
    @(negedge clk); @(negedge clk); #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_wren", bus.wr_en, 0);
    chk("rst_addr", bus.wr_addr, 0);
    chk("rst_data", bus.wr_data, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("idle_wren", bus.wr_en, 0);
    chk("idle_busy", bus.busy, 0);

    // Basic fill; inputs changed after start must not matter.
    d0 = done_cnt;
    set_rect(8'd2, 7'd3, 8'd4, 7'd4, 12'hF00);
    kick();
    set_rect(8'd0, 7'd0, 8'd100, 7'd100, 12'h0AA);
    q = '{482, 483, 484, 642, 643, 644};
    run_seq("basic", q, 12'hF00);
    chk("basic_done_cnt", done_cnt - d0, 1);

    // Swapped and clipped corners.
    set_rect(8'd200, 7'd125, 8'd158, 7'd118, 12'hABC);
    kick();
    q = '{19038, 19039, 19198, 19199};
    run_seq("clip", q, 12'hABC);
    chk("clip_max_addr", last_addr, 19199);

    // Stalls with slot_free pattern 1,0,0,1.
    w0 = wr_count;
    set_rect(8'd2, 7'd3, 8'd4, 7'd4, 12'h0F0);
    kick();
    q = '{482, 483, 484, 642, 643, 644};
    idx = 0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      bus.slot_free = pat[c % 4];
      #1;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      chk("stall_addr", bus.wr_addr, q[idx]);
      chk("stall_wren", bus.wr_en, bus.slot_free);
      if (bus.wr_en === 1'b1) idx++;
    end
    chk("stall_done_seen", seen, 1);
    chk("stall_writes", idx, 6);
    chk("stall_wr_count", wr_count - w0, 6);
    chk("stall_done_wren", bus.wr_en, 0);
    bus.slot_free = 1'b1;
    @(negedge clk); #1;

    // Single pixel with a start pulse during FILL that must be ignored.
    set_rect(8'd0, 7'd0, 8'd0, 7'd0, 12'h123);
    kick();
    chk("one_load_busy", bus.busy, 1);
    @(negedge clk); #1;
    chk("one_wren", bus.wr_en, 1);
    chk("one_addr", bus.wr_addr, 0);
    bus.start = 1'b1;
    set_rect(8'd5, 7'd5, 8'd6, 7'd6, 12'h456);
    @(negedge clk); #1;
    chk("one_done", bus.done, 1);
    bus.start = 1'b0;
    @(negedge clk); #1;
    chk("one_idle_busy", bus.busy, 0);
    @(negedge clk); #1;
    chk("one_ignored_busy", bus.busy, 0);

    // start held high: back-to-back fills, inputs resampled.
    set_rect(8'd0, 7'd0, 8'd0, 7'd0, 12'h111);
    bus.start = 1'b1;
    @(negedge clk); #1;
    chk("b2b_load1_busy", bus.busy, 1);
    chk("b2b_load1_wren", bus.wr_en, 0);
    @(negedge clk); #1;
    chk("b2b_fill1_addr", bus.wr_addr, 0);
    chk("b2b_fill1_wren", bus.wr_en, 1);
    set_rect(8'd1, 7'd0, 8'd1, 7'd0, 12'h222);
    @(negedge clk); #1;
    chk("b2b_done1", bus.done, 1);
    @(negedge clk); #1;
    chk("b2b_idle_busy", bus.busy, 0);
    chk("b2b_idle_done", bus.done, 0);
    @(negedge clk); #1;
    chk("b2b_load2_busy", bus.busy, 1);
    bus.start = 1'b0;
    @(negedge clk); #1;
    chk("b2b_fill2_addr", bus.wr_addr, 1);
    chk("b2b_fill2_data", bus.wr_data, 12'h222);
    @(negedge clk); #1;
    chk("b2b_done2", bus.done, 1);
    @(negedge clk); #1;

    // Reset after 20 writes of a 10x10 fill.
    w0 = wr_count;
    d0 = done_cnt;
    set_rect(8'd0, 7'd0, 8'd9, 7'd9, 12'hFFF);
    kick();
    k = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk); #1;
      if (bus.wr_en === 1'b1) k++;
      if (k == 20) break;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_wren", bus.wr_en, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_addr", bus.wr_addr, 0);
    chk("mid_rst_writes", wr_count - w0, 20);
    chk("mid_rst_last", last_addr, 169);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("mid_rst_after_busy", bus.busy, 0);
    @(negedge clk); #1;
    chk("mid_rst_no_writes", wr_count - w0, 20);
    chk("mid_rst_no_done", done_cnt - d0, 0);

    // Full screen.
    w0 = wr_count;
    d0 = done_cnt;
    set_rect(8'd0, 7'd0, 8'd159, 7'd119, 12'h5A5);
    kick();
    k = 0;
    gaps = 0;
    seen = 1'b0;
    for (int c = 0; c < 19300; c++) begin
      @(negedge clk); #1;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.wr_en === 1'b1) begin
        if (bus.wr_addr !== 15'(k)) gaps++;
        k++;
      end
    end
    chk("full_done_seen", seen, 1);
    chk("full_pixels", k, 19200);
    chk("full_gaps", gaps, 0);
    chk("full_last_addr", last_addr, 19199);
    chk("full_wr_count", wr_count - w0, 19200);
    repeat (3) @(negedge clk);
    #1;
    chk("full_done_once", done_cnt - d0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rect_fill_engine.md
Name: rect_fill_engine

Overview:
- Drawing stage directly upstream of the frame-buffer RAM write port.
- On start, fills an axis-aligned rectangle of the WIDTH x HEIGHT picture buffer with one 12-bit colour, one pixel per free write slot.
- Its wr_addr/wr_data/wr_en drive the buffer RAM write mux alongside the cursor and clear paths.
- slot_free is driven by the display's ~screen_on, so the engine only writes while the display is not reading.

Parameters:
WIDTH, 160, buffer width in pixels; row stride for addressing
HEIGHT, 120, buffer height in pixels
ADDR_W, 15, buffer address width; must satisfy WIDTH*HEIGHT <= 2**ADDR_W

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  request a fill; sampled only in IDLE
x0  input  8  corner A column
y0  input  7  corner A row
x1  input  8  corner B column
y1  input  7  corner B row
colour  input  12  fill colour, RGB 4:4:4
slot_free  input  1  1 = RAM write port available this cycle
busy  output  1  1 while a fill is in progress (LOAD or FILL)
done  output  1  one-cycle pulse after the last pixel is written
wr_en  output  1  RAM write enable
wr_addr  output  ADDR_W  RAM write address = row*WIDTH + col
wr_data  output  12  RAM write data

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; busy=0, done=0, wr_en=0.
  - wr_addr=0, wr_data=0; all internal registers cleared.
  - Takes effect immediately, even mid-fill; the partial rectangle is left in RAM and no done pulse is produced.
- States: IDLE -> LOAD -> FILL -> DONE -> IDLE.
- IDLE:
  - On start=1, register x0/y0/x1/y1/colour and go to LOAD.
  - start in any other state is ignored; no queueing.
- LOAD (exactly 1 cycle):
  - Clip each x to WIDTH-1 and each y to HEIGHT-1.
  - xl=min(x), xr=max(x), yt=min(y), yb=max(y).
  - col=xl, row=yt, row_base=yt*WIDTH. Compute row_base by shift-add (WIDTH=160: (y<<7)+(y<<5)); no generic multiplier.
  - Go to FILL.
- FILL:
  - wr_en = slot_free, combinational from slot_free and state.
  - wr_addr = row_base + col, registered operands, ADDR_W bits.
  - wr_data = latched colour.
  - Position advances only on cycles with wr_en=1:
    - if col<xr: col+1.
    - else if row<yb: col=xl, row+1, row_base+WIDTH.
    - else (last pixel): go to DONE.
  - slot_free=0 stalls the position with no skip and no duplicate; the address is held.
- DONE (1 cycle): done=1, busy=0, then IDLE.
- busy=1 in LOAD and FILL only.
- Latency:
  - First write is possible 2 cycles after the start edge (IDLE->LOAD->FILL).
  - The fill writes exactly (xr-xl+1)*(yb-yt+1) pixels, each exactly once, in row-major order.
- Degenerate cases:
  - x0=x1 and y0=y1: single write, then done.
  - Swapped corners produce the same rectangle as normal order.
- Out-of-range inputs (x>=WIDTH, y>=HEIGHT) are clipped, never wrapped; addresses never exceed WIDTH*HEIGHT-1.
- start held high continuously:
  - Triggers a new fill each time IDLE is re-entered (one idle cycle between fills).
  - Inputs are resampled at each new fill.
- Changing inputs during LOAD, FILL or DONE has no effect on the current fill.
- wr_en is 0 in IDLE, LOAD and DONE regardless of slot_free.

Test Plan:
- Reset mid-fill: start a (0,0)-(9,9) fill, assert reset=0 after 20 writes -> wr_en/busy/done=0 immediately; no further writes; after release, state is IDLE.
- Basic fill: x0=2,y0=3,x1=4,y1=4, colour=12'hF00, slot_free=1 -> 6 writes to addresses 482,483,484,642,643,644, all data 12'hF00; done pulses 1 cycle after address 644; busy low with done.
- Swapped and clipped corners: x0=200,y0=125,x1=158,y1=118 -> rectangle cols 158-159, rows 118-119; addresses 19038,19039,19198,19199; max address 19199.
- Stall: same 6-pixel fill with slot_free toggling 1,0,0,1,... -> each address written exactly once, in order; wr_addr held during slot_free=0; total writes 6.
- Single pixel plus ignored start: x=y=0 -> one write at address 0; a start pulse during FILL is ignored; start held high gives back-to-back fills separated by DONE and one IDLE cycle.
- Full screen: (0,0)-(159,119), slot_free=1 -> 19200 writes covering addresses 0..19199 with no gaps; done exactly once.
